// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button front end: synchronises and debounces the raw
// active-low button, turns each clean press into one held request for the
// light controller, and locks out further presses until the pedestrian phase
// has been served and a quiet window has elapsed.
module ped_request_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LOCKOUT_CYCLES  = 250_000_000,
    parameter int unsigned CNT_W           = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       serve,
    output logic       click,
    output logic       press_pulse,
    output logic       btn_clean,
    output logic       busy,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOCKOUT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             btn_sync;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             clean_q, clean_d;
    logic             clean_dly_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] lk_cnt_q, lk_cnt_d;
    logic [7:0]       press_count_q, press_count_d;

    // Two-flop synchroniser; flops idle at 1 so reset looks like a released button.
    // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    assign btn_sync = ~sync2_q;

    // Debounce next state: count consecutive mismatch cycles, flip once the run is long enough.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        db_cnt_d = '0;
        clean_d  = clean_q;
        if (btn_sync != clean_q) begin
            if (db_cnt_q == DB_LAST) begin
                clean_d = btn_sync;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce registers, plus the one-cycle delayed clean level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt_q    <= '0;
            clean_q     <= 1'b0;
            clean_dly_q <= 1'b0;
        end else begin
            db_cnt_q    <= db_cnt_d;
            clean_q     <= clean_d;
            clean_dly_q <= clean_q;
        end
    end

    assign btn_clean   = clean_q;
    assign press_pulse = clean_q & ~clean_dly_q;

    // Request FSM state register together with the lockout timer and press counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            lk_cnt_q      <= '0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            lk_cnt_q      <= lk_cnt_d;
            press_count_q <= press_count_d;
        end
    end

    // Request FSM next state: accept a press only when idle, lock out after service.
    always_comb begin
        state_d       = state_q;
        lk_cnt_d      = lk_cnt_q;
        press_count_d = press_count_q;
        case (state_q)
            IDLE: begin
                if (press_pulse) begin
                    state_d = PENDING;
                    if (press_count_q != 8'hFF) begin
                        press_count_d = press_count_q + 8'd1;
                    end
                end
            end
            PENDING: begin
                if (serve) begin
                    state_d  = LOCKOUT;
                    lk_cnt_d = LK_LOAD;
                end
            end
            LOCKOUT: begin
                if (lk_cnt_q != '0) begin
                    lk_cnt_d = lk_cnt_q - CNT_W'(1);
                end else if (!serve) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request FSM outputs decoded from the registered state.
    always_comb begin
        click = 1'b0;
        busy  = 1'b0;
        case (state_q)
            PENDING: begin
                click = 1'b1;
                busy  = 1'b1;
            end
            LOCKOUT: busy = 1'b1;
            default: begin
                click = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

    assign press_count = press_count_q;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Self-checking bench for ped_request_conditioner with short debounce and
// lockout windows. A cycle-based reference model (sample history, mismatch
// run length, request timestamps) runs alongside every stimulus step; directed
// tables and hand sequences additionally compare against fixed expectations.
module tb_ped_request_conditioner;

    localparam int D = 4;
    localparam int L = 10;

    logic       clk;
    logic       rst;
    logic       btn_n;
    logic       serve;
    logic       click;
    logic       press_pulse;
    logic       btn_clean;
    logic       busy;
    logic [7:0] press_count;
    logic [11:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    ped_request_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L),
        .CNT_W          (28)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .serve      (serve),
        .click      (click),
        .press_pulse(press_pulse),
        .btn_clean  (btn_clean),
        .busy       (busy),
        .press_count(press_count)
    );

    assign outs = {click, busy, btn_clean, press_pulse, press_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack expected outputs in the same order as 'outs'.
    function automatic logic [11:0] pk(input logic c, input logic b, input logic cl,
                                       input logic pu, input logic [7:0] cnt);
        return {c, b, cl, pu, cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int   m_edge;
    logic m_s1, m_s2;          // raw samples from the last two edges
    logic m_clean, m_clean_prev;
    int   m_run;               // consecutive edges where synced level differed from clean
    bit   m_pending, m_locked;
    int   m_lock_end;          // edge index at which the lockout may end
    int   m_count;

    task automatic model_reset();
        m_edge = 0; m_s1 = 1'b1; m_s2 = 1'b1;
        m_clean = 1'b0; m_clean_prev = 1'b0; m_run = 0;
        m_pending = 0; m_locked = 0; m_lock_end = 0; m_count = 0;
    endtask

    task automatic model_edge(input logic b, input logic s);
        logic pulse;
        logic sync;
        pulse = m_clean & ~m_clean_prev;
        sync  = ~m_s2;
        if (m_pending) begin
            if (s) begin
                m_pending  = 0;
                m_locked   = 1;
                m_lock_end = m_edge + L;
            end
        end else if (m_locked) begin
            if (m_edge >= m_lock_end && !s) m_locked = 0;
        end else if (pulse) begin
            m_pending = 1;
            if (m_count < 255) m_count++;
        end
        m_clean_prev = m_clean;
        if (sync != m_clean) begin
            m_run++;
            if (m_run == D) begin
                m_clean = sync;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = b;
        m_edge++;
    endtask

    function automatic logic [11:0] m_out();
        return pk(m_pending, m_pending | m_locked, m_clean, m_clean & ~m_clean_prev,
                  m_count[7:0]);
    endfunction

    // One clock: drive at negedge, model advances at posedge, compare at next negedge.
    task automatic step(input logic b, input logic s);
        btn_n = b;
        serve = s;
        @(posedge clk);
        model_edge(b, s);
        @(negedge clk);
        check($sformatf("model@%0d", m_edge), outs, m_out());
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs must clear at once.
    task automatic do_reset();
        btn_n = 1'b1;
        serve = 1'b0;
        #2 rst = 1'b0;
        #1 check("reset_async", outs, pk(0, 0, 0, 0, 8'd0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int          n;
        logic        b;
        logic        s;
        logic [11:0] e;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic bv, sv;
        int   brun, srun;

        rst = 1'b0; btn_n = 1'b1; serve = 1'b0;
        model_reset();

        // Directed vectors: {cycles applied, btn_n, serve, expected outputs afterwards}
        vecs.push_back('{n: 5, b: 1'b0, s: 1'b0, e: pk(0, 0, 0, 0, 8'd0)});
        vecs.push_back('{n: 1, b: 1'b0, s: 1'b0, e: pk(0, 0, 1, 1, 8'd0)});
        vecs.push_back('{n: 1, b: 1'b0, s: 1'b0, e: pk(1, 1, 1, 0, 8'd1)});
        vecs.push_back('{n: 3, b: 1'b1, s: 1'b0, e: pk(1, 1, 1, 0, 8'd1)});
        vecs.push_back('{n: 3, b: 1'b1, s: 1'b0, e: pk(1, 1, 0, 0, 8'd1)});
        vecs.push_back('{n: 1, b: 1'b1, s: 1'b1, e: pk(0, 1, 0, 0, 8'd1)});
        vecs.push_back('{n: 4, b: 1'b1, s: 1'b1, e: pk(0, 1, 0, 0, 8'd1)});
        vecs.push_back('{n: 5, b: 1'b1, s: 1'b0, e: pk(0, 1, 0, 0, 8'd1)});
        vecs.push_back('{n: 1, b: 1'b1, s: 1'b0, e: pk(0, 0, 0, 0, 8'd1)});
        vecs.push_back('{n: 1, b: 1'b0, s: 1'b0, e: pk(0, 0, 0, 0, 8'd1)});
        vecs.push_back('{n: 1, b: 1'b1, s: 1'b0, e: pk(0, 0, 0, 0, 8'd1)});
        vecs.push_back('{n: 2, b: 1'b0, s: 1'b0, e: pk(0, 0, 0, 0, 8'd1)});
        vecs.push_back('{n: 1, b: 1'b1, s: 1'b0, e: pk(0, 0, 0, 0, 8'd1)});
        vecs.push_back('{n: 3, b: 1'b0, s: 1'b0, e: pk(0, 0, 0, 0, 8'd1)});
        vecs.push_back('{n: 1, b: 1'b1, s: 1'b0, e: pk(0, 0, 0, 0, 8'd1)});
        vecs.push_back('{n: 6, b: 1'b1, s: 1'b0, e: pk(0, 0, 0, 0, 8'd1)});

        // Power-on reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_state", outs, pk(0, 0, 0, 0, 8'd0));
        rst = 1'b1;

        // Press latency, hold until serve, lockout length, glitch rejection
        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) step(vecs[i].b, vecs[i].s);
            check($sformatf("vec[%0d]", i), outs, vecs[i].e);
        end

        // Extra presses while pending and during lockout are absorbed
        do_reset();
        repeat (7) step(1'b0, 1'b0);
        check("t4_first", outs, pk(1, 1, 1, 0, 8'd1));
        repeat (6) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        check("t4_pending_press", outs, pk(1, 1, 1, 0, 8'd1));
        repeat (6) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (7) step(1'b0, 1'b0);
        check("t4_lock_press", outs, pk(0, 1, 1, 0, 8'd1));
        repeat (10) step(1'b0, 1'b0);
        check("t4_held_through", outs, pk(0, 0, 1, 0, 8'd1));
        repeat (6) step(1'b1, 1'b0);
        check("t4_released", outs, pk(0, 0, 0, 0, 8'd1));
        repeat (7) step(1'b0, 1'b0);
        check("t4_fresh_press", outs, pk(1, 1, 1, 0, 8'd2));

        // Reset while pending drops the request for good
        do_reset();
        repeat (20) step(1'b1, 1'b0);
        check("t5_after_reset", outs, pk(0, 0, 0, 0, 8'd0));

        // Press pulse coincident with serve, then lockout expiry while serve stays high
        repeat (6) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("sim_pending", outs, pk(1, 1, 1, 0, 8'd1));
        step(1'b0, 1'b1);
        check("sim_lockout", outs, pk(0, 1, 1, 0, 8'd1));
        repeat (12) step(1'b0, 1'b1);
        check("expiry_serve_high", outs, pk(0, 1, 1, 0, 8'd1));
        step(1'b0, 1'b0);
        check("expiry_serve_low", outs, pk(0, 0, 1, 0, 8'd1));
        repeat (6) step(1'b1, 1'b0);

        // Saturation of press_count
        do_reset();
        for (int i = 0; i < 300; i++) begin
            repeat (7) step(1'b0, 1'b0);
            check("sat_click", click, 1'b1);
            check("sat_count", press_count, (i + 1 > 255) ? 255 : i + 1);
            repeat (6) step(1'b1, 1'b0);
            step(1'b1, 1'b1);
            repeat (10) step(1'b1, 1'b0);
        end
        check("sat_final", outs, pk(0, 0, 0, 0, 8'd255));

        // Random runs of button and serve levels against the model
        do_reset();
        bv = 1'b1; sv = 1'b0; brun = 0; srun = 0;
        for (int c = 0; c < 4000; c++) begin
            if (brun == 0) begin
                bv   = 1'($urandom_range(0, 1));
                brun = $urandom_range(1, 10);
            end
            if (srun == 0) begin
                sv   = 1'($urandom_range(0, 1));
                srun = $urandom_range(1, 15);
            end
            brun--;
            srun--;
            step(bv, sv);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
